jtopl_timer_bank: RTL

//  Parametrised bank of NTIMER up-counting OPL-style timers. Generalises the fixed A/B timer pair:
//  - any number of timers, any counter width
//  - per-timer prescaler ratio
//  - per-timer one-shot/auto-reload mode
//  - per-timer flag mask

---
 rtl/jtopl_timer_bank.sv | 132 +++++++++++++
 1 files changed

// File: rtl/jtopl_timer_bank.sv
// jtopl_timer_bank: bank of NTIMER up-counting OPL-style timers.
// Each timer has its own prescaler (2^(PRE0+PRESTEP*i) zero pulses per tick),
// reload value, one-shot/auto-reload mode and flag mask. The sticky flags are
// combined into an active-low interrupt request.
module jtopl_timer_bank #(
  parameter int NTIMER  = 2,
  parameter int CW      = 8,
  parameter int PRE0    = 2,
  parameter int PRESTEP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 zero,
  input  logic [NTIMER*CW-1:0] value,
  input  logic [NTIMER-1:0]    load,
  input  logic [NTIMER-1:0]    oneshot,
  input  logic [NTIMER-1:0]    mask,
  input  logic [NTIMER-1:0]    clr_flag,
  input  logic                 clr_all,
  output logic [NTIMER-1:0]    flag,
  output logic [NTIMER-1:0]    overflow,
  output logic [NTIMER-1:0]    done,
  output logic                 irq_n
);

  // Prescaler storage is sized for the slowest timer; each timer only uses
  // its own low PW bits (the rest stay zero through the mask).
  localparam int PWM = PRE0 + PRESTEP * (NTIMER - 1) + 1;
  localparam logic [PWM-1:0] P_ONE = PWM'(1);
  localparam logic [CW-1:0]  C_ONE = CW'(1);

  // After reset the load edge detector needs one cen cycle to sample the
  // current load level, so a load held high across reset is not an edge.
  logic r_primed;

  // Edge-detector priming flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_primed <= 1'b0;
    end else if (cen) begin
      r_primed <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NTIMER; gi++) begin : g_tmr
      localparam int PW = PRE0 + PRESTEP * gi;
      localparam logic [PWM-1:0] PMASK = PWM'((64'd1 << PW) - 64'd1);

      logic [CW-1:0]  r_cnt;
      logic [PWM-1:0] r_pre;
      logic           r_load_d;
      logic           r_arm;
      logic           r_flag;
      logic           r_ovf;
      logic           r_done;

      logic [CW-1:0]  w_value;
      logic           w_rise;
      logic           w_run;
      logic           w_tick;
      logic           w_wrap;
      logic           w_set;
      logic           w_clr;

      assign w_value = value[gi*CW +: CW];
      assign w_rise  = r_primed & load[gi] & ~r_load_d;
      // r_arm is only set by a genuine load edge, so a timer never runs on
      // a load level that was already high when reset was released.
      assign w_run   = r_arm & load[gi] & ~r_done & ~w_rise;
      assign w_tick  = w_run & zero & ((r_pre & PMASK) == PMASK);
      assign w_wrap  = w_tick & (&r_cnt);
      assign w_set   = w_wrap & ~mask[gi];
      assign w_clr   = clr_flag[gi] | clr_all;

      // Counter, prescaler, one-shot state and overflow pulse of timer gi.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_pre    <= '0;
          r_load_d <= 1'b0;
          r_arm    <= 1'b0;
          r_ovf    <= 1'b0;
          r_done   <= 1'b0;
        end else if (cen) begin
          r_load_d <= load[gi];
          r_ovf    <= w_wrap;
          if (w_rise) begin
            r_cnt  <= w_value;
            r_pre  <= '0;
            r_done <= 1'b0;
            r_arm  <= 1'b1;
          end else if (w_run && zero) begin
            r_pre <= (r_pre + P_ONE) & PMASK;
            if (w_tick) begin
              if (&r_cnt) begin
                // value is sampled here, so late writes take effect now
                r_cnt <= w_value;
                if (oneshot[gi]) begin
                  r_done <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + C_ONE;
              end
            end
          end
        end
      end

      // Sticky flag: a new overflow beats a simultaneous clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_flag <= 1'b0;
        end else if (cen) begin
          if (w_set) begin
            r_flag <= 1'b1;
          end else if (w_clr) begin
            r_flag <= 1'b0;
          end
        end
      end

      assign flag[gi]     = r_flag;
      assign overflow[gi] = r_ovf;
      assign done[gi]     = r_done;
    end
  endgenerate

  assign irq_n = ~|flag;

endmodule
